// File: rtl/pakout_chk_pkg.sv
// Shared field widths, generator state encoding and error-bit indices for pakout_chk.
package pakout_chk_pkg;

    localparam int NS_ADDRESS_SIZE = 4;
    localparam int NS_DATA_SIZE    = 4;
    localparam int NS_REDUN_SIZE   = 4;

    typedef enum logic [1:0] {
        GEN_IDLE = 2'd0,
        GEN_LOAD = 2'd1,
        GEN_REQ  = 2'd2,
        GEN_REL  = 2'd3
    } gen_state_e;

    localparam int ERR_SRC = 0;
    localparam int ERR_SEQ = 1;
    localparam int ERR_RED = 2;
    localparam int ERR_DST = 3;
    localparam int ERR_W   = 4;

endpackage

// File: rtl/calc_redun.sv
// Redundancy generator: XOR-fold of {src,dst,dat} into RSZ-bit chunks, top chunk zero-padded.
module calc_redun import pakout_chk_pkg::*; #(
    parameter int ASZ = NS_ADDRESS_SIZE,
    parameter int DSZ = NS_DATA_SIZE,
    parameter int RSZ = NS_REDUN_SIZE
) (
    input  logic [ASZ-1:0] src,
    input  logic [ASZ-1:0] dst,
    input  logic [DSZ-1:0] dat,
    output logic [RSZ-1:0] red
);

    localparam int TOT    = 2 * ASZ + DSZ;
    localparam int NCHUNK = (TOT + RSZ - 1) / RSZ;
    localparam int PW     = NCHUNK * RSZ;

    logic [PW-1:0] padded;

    assign padded = PW'({src, dst, dat});

    // Fold every RSZ-bit chunk of the padded packet into the redundancy value
    always_comb begin
        red = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            red = red ^ padded[i*RSZ +: RSZ];
        end
    end

endmodule

// File: rtl/pakout_chk_lane.sv
// One channel: packet generator on the outgoing req/ack link and packet checker on the incoming one.
module pakout_chk_lane import pakout_chk_pkg::*; #(
    parameter int MIN_ADDR = 1,
    parameter int MAX_ADDR = 1,
    parameter int SRC_ADDR = 3,
    parameter int ASZ      = NS_ADDRESS_SIZE,
    parameter int DSZ      = NS_DATA_SIZE,
    parameter int RSZ      = NS_REDUN_SIZE,
    parameter int RED_MODE = 1,
    parameter int INIT_RED = 15,
    parameter int CW       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [ASZ-1:0]   o_src,
    output logic [ASZ-1:0]   o_dst,
    output logic [DSZ-1:0]   o_dat,
    output logic [RSZ-1:0]   o_red,
    output logic             o_req,
    input  logic             o_ack,
    input  logic [ASZ-1:0]   i_src,
    input  logic [ASZ-1:0]   i_dst,
    input  logic [DSZ-1:0]   i_dat,
    input  logic [RSZ-1:0]   i_red,
    input  logic             i_req,
    output logic             i_ack,
    output logic             busy,
    output logic [ERR_W-1:0] err,
    output logic [3:0]       info,
    output logic [3:0]       sent_nib,
    output logic [3:0]       recv_nib
);

    localparam logic [ASZ-1:0] SRC_C = ASZ'(SRC_ADDR);
    localparam logic [ASZ-1:0] MIN_C = ASZ'(MIN_ADDR);
    localparam logic [ASZ-1:0] MAX_C = ASZ'(MAX_ADDR);
    localparam logic [RSZ-1:0] RED_C = RSZ'(INIT_RED);

    gen_state_e     state, state_nxt;
    logic           load, sent_inc;
    logic [ASZ-1:0] dst_q, dst_next;
    logic [DSZ-1:0] dat_q, seq_q;
    logic [RSZ-1:0] red_q, red_gen_calc, red_gen;
    logic [CW-1:0]  sent_q;

    logic           ack_q, cap_vld, have_prev;
    logic [ASZ-1:0] cap_src, cap_dst;
    logic [DSZ-1:0] cap_dat, prev_dat;
    logic [RSZ-1:0] cap_red, red_chk_calc, red_exp;
    logic [ERR_W-1:0] err_q, err_new;
    logic [3:0]     info_q, info_new;
    logic [CW-1:0]  recv_q;

    assign dst_next = (dst_q == MAX_C) ? MIN_C : dst_q + ASZ'(1);

    calc_redun #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_red_gen (
        .src(SRC_C), .dst(dst_next), .dat(seq_q), .red(red_gen_calc)
    );

    assign red_gen = (RED_MODE != 0) ? red_gen_calc : RED_C;

    // Generator next-state: fields are loaded once, on the LOAD->REQ step, so they hold through REQ and REL
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        sent_inc  = 1'b0;
        case (state)
            GEN_IDLE: if (en) state_nxt = GEN_LOAD;
            GEN_LOAD: if (!o_ack) begin
                state_nxt = GEN_REQ;
                load      = 1'b1;
            end
            GEN_REQ: if (o_ack) begin
                state_nxt = GEN_REL;
                sent_inc  = 1'b1;
            end
            GEN_REL: if (!o_ack) state_nxt = GEN_IDLE;
            default: state_nxt = GEN_IDLE;
        endcase
    end

    // Generator state, outgoing fields, sequence counter and sent counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= GEN_IDLE;
            dst_q  <= MAX_C;
            dat_q  <= '0;
            seq_q  <= '0;
            red_q  <= RED_C;
            sent_q <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                dst_q <= dst_next;
                dat_q <= seq_q;
                seq_q <= seq_q + DSZ'(1);
                red_q <= red_gen;
            end
            if (sent_inc) sent_q <= sent_q + CW'(1);
        end
    end

    assign o_src    = SRC_C;
    assign o_dst    = dst_q;
    assign o_dat    = dat_q;
    assign o_red    = red_q;
    assign o_req    = (state == GEN_REQ);
    assign busy     = (state != GEN_IDLE);
    assign sent_nib = 4'(sent_q);

    // Checker handshake: capture a new request while not yet acknowledging, release once request falls
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q   <= 1'b0;
            cap_vld <= 1'b0;
            cap_src <= '0;
            cap_dst <= '0;
            cap_dat <= '0;
            cap_red <= '0;
        end else begin
            cap_vld <= i_req && !ack_q;
            if (i_req && !ack_q) begin
                ack_q   <= 1'b1;
                cap_src <= i_src;
                cap_dst <= i_dst;
                cap_dat <= i_dat;
                cap_red <= i_red;
            end else if (!i_req) begin
                ack_q <= 1'b0;
            end
        end
    end

    calc_redun #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_red_chk (
        .src(cap_src), .dst(cap_dst), .dat(cap_dat), .red(red_chk_calc)
    );

    assign red_exp = (RED_MODE != 0) ? red_chk_calc : RED_C;

    // Evaluate the captured packet and pick the info nibble of the highest-priority failing field
    always_comb begin
        err_new          = '0;
        err_new[ERR_SRC] = (cap_src != SRC_C);
        err_new[ERR_SEQ] = have_prev && (cap_dat != prev_dat + DSZ'(1));
        err_new[ERR_RED] = (cap_red != red_exp);
        err_new[ERR_DST] = (cap_dst < MIN_C) || (cap_dst > MAX_C);
        info_new         = 4'(cap_dst);
        if (err_new[ERR_SRC])      info_new = 4'(cap_src);
        else if (err_new[ERR_SEQ]) info_new = 4'(cap_dat);
        else if (err_new[ERR_RED]) info_new = 4'(cap_red);
    end

    // Sticky error flags, first-error info, sequence baseline and saturating receive counter
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q     <= '0;
            info_q    <= '0;
            have_prev <= 1'b0;
            prev_dat  <= '0;
            recv_q    <= '0;
        end else if (cap_vld) begin
            err_q <= err_q | err_new;
            if (err_q == '0 && err_new != '0) info_q <= info_new;
            have_prev <= 1'b1;
            prev_dat  <= cap_dat;
            if (recv_q != '1) recv_q <= recv_q + CW'(1);
        end
    end

    assign i_ack    = ack_q;
    assign err      = err_q;
    assign info     = info_q;
    assign recv_nib = 4'(recv_q);

endmodule

// File: rtl/pakout_chk.sv
// Multi-channel packet-out exerciser/checker with a registered debug view of any channel.
module pakout_chk import pakout_chk_pkg::*; #(
    parameter int NCH      = 2,
    parameter int MIN_ADDR = 1,
    parameter int MAX_ADDR = 1,
    parameter int SRC_ADDR = 3,
    parameter int ASZ      = NS_ADDRESS_SIZE,
    parameter int DSZ      = NS_DATA_SIZE,
    parameter int RSZ      = NS_REDUN_SIZE,
    parameter int RED_MODE = 1,
    parameter int INIT_RED = 15,
    parameter int CW       = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NCH-1:0]     i_en,
    output logic [NCH*ASZ-1:0] o_src,
    output logic [NCH*ASZ-1:0] o_dst,
    output logic [NCH*DSZ-1:0] o_dat,
    output logic [NCH*RSZ-1:0] o_red,
    output logic [NCH-1:0]     o_req,
    input  logic [NCH-1:0]     o_ack,
    input  logic [NCH*ASZ-1:0] i_src,
    input  logic [NCH*ASZ-1:0] i_dst,
    input  logic [NCH*DSZ-1:0] i_dat,
    input  logic [NCH*RSZ-1:0] i_red,
    input  logic [NCH-1:0]     i_req,
    output logic [NCH-1:0]     i_ack,
    input  logic [3:0]         dbg_case,
    output logic [3:0]         dbg_leds,
    output logic [3:0]         dbg_disp0,
    output logic [3:0]         dbg_disp1,
    output logic [NCH-1:0]     o_err
);

    logic             busy_w [NCH];
    logic [ERR_W-1:0] err_w  [NCH];
    logic [3:0]       info_w [NCH];
    logic [3:0]       sent_w [NCH];
    logic [3:0]       recv_w [NCH];
    logic [3:0]       leds_n, disp0_n, disp1_n;

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        pakout_chk_lane #(
            .MIN_ADDR(MIN_ADDR), .MAX_ADDR(MAX_ADDR), .SRC_ADDR(SRC_ADDR),
            .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ),
            .RED_MODE(RED_MODE), .INIT_RED(INIT_RED), .CW(CW)
        ) u_lane (
            .clk     (i_clk),
            .rst     (i_rst),
            .en      (i_en[k]),
            .o_src   (o_src[k*ASZ +: ASZ]),
            .o_dst   (o_dst[k*ASZ +: ASZ]),
            .o_dat   (o_dat[k*DSZ +: DSZ]),
            .o_red   (o_red[k*RSZ +: RSZ]),
            .o_req   (o_req[k]),
            .o_ack   (o_ack[k]),
            .i_src   (i_src[k*ASZ +: ASZ]),
            .i_dst   (i_dst[k*ASZ +: ASZ]),
            .i_dat   (i_dat[k*DSZ +: DSZ]),
            .i_red   (i_red[k*RSZ +: RSZ]),
            .i_req   (i_req[k]),
            .i_ack   (i_ack[k]),
            .busy    (busy_w[k]),
            .err     (err_w[k]),
            .info    (info_w[k]),
            .sent_nib(sent_w[k]),
            .recv_nib(recv_w[k])
        );
    end

    // Debug mux: channel from the upper selector bits, sink or source view from bit 0, zero when out of range
    always_comb begin
        leds_n  = '0;
        disp0_n = '0;
        disp1_n = '0;
        for (int k = 0; k < NCH; k++) begin
            if (dbg_case[3:1] == 3'(k)) begin
                if (dbg_case[0]) begin
                    leds_n  = err_w[k];
                    disp0_n = info_w[k];
                    disp1_n = recv_w[k];
                end else begin
                    leds_n  = {i_en[k], busy_w[k], o_req[k], o_ack[k]};
                    disp0_n = sent_w[k];
                    disp1_n = 4'(o_dst[k*ASZ +: ASZ]);
                end
            end
        end
    end

    // Registered debug outputs and per-channel error summary
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dbg_leds  <= '0;
            dbg_disp0 <= '0;
            dbg_disp1 <= '0;
            o_err     <= '0;
        end else begin
            dbg_leds  <= leds_n;
            dbg_disp0 <= disp0_n;
            dbg_disp1 <= disp1_n;
            for (int k = 0; k < NCH; k++) o_err[k] <= |err_w[k];
        end
    end

endmodule

// File: tb/tb_pakout_chk.sv
// Self-checking bench for pakout_chk: loopback scoreboard, fault injection, slow peer and debug view.
module tb_pakout_chk;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [1:0] en = 2'b00;
    logic       loop = 1'b0;
    logic [3:0] dbg_case = 4'h0;
    logic [1:0] tb_o_ack = 2'b00;
    logic [7:0] tb_i_src = '0, tb_i_dst = '0, tb_i_dat = '0, tb_i_red = '0;
    logic [1:0] tb_i_req = 2'b00;

    wire [7:0] o_src, o_dst, o_dat, o_red;
    wire [1:0] o_req, i_ack, o_err, o_ack_w, i_req_w;
    wire [7:0] i_src_w, i_dst_w, i_dat_w, i_red_w;
    wire [3:0] dbg_leds, dbg_disp0, dbg_disp1;

    assign o_ack_w = loop ? i_ack : tb_o_ack;
    assign i_req_w = loop ? o_req : tb_i_req;
    assign i_src_w = loop ? o_src : tb_i_src;
    assign i_dst_w = loop ? o_dst : tb_i_dst;
    assign i_dat_w = loop ? o_dat : tb_i_dat;
    assign i_red_w = loop ? o_red : tb_i_red;

    pakout_chk #(
        .NCH(2), .MIN_ADDR(1), .MAX_ADDR(3), .SRC_ADDR(3), .ASZ(4), .DSZ(4), .RSZ(4),
        .RED_MODE(1), .INIT_RED(15), .CW(16)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en),
        .o_src(o_src), .o_dst(o_dst), .o_dat(o_dat), .o_red(o_red), .o_req(o_req), .o_ack(o_ack_w),
        .i_src(i_src_w), .i_dst(i_dst_w), .i_dat(i_dat_w), .i_red(i_red_w), .i_req(i_req_w), .i_ack(i_ack),
        .dbg_case(dbg_case), .dbg_leds(dbg_leds), .dbg_disp0(dbg_disp0), .dbg_disp1(dbg_disp1),
        .o_err(o_err)
    );

    logic [1:0] b_en = 2'b00, b_o_ack = 2'b00, b_i_req = 2'b00;
    logic [3:0] b_dbg_case = 4'h0;
    logic [7:0] b_i_src = '0, b_i_dst = '0, b_i_dat = '0, b_i_red = '0;
    wire  [7:0] b_o_src, b_o_dst, b_o_dat, b_o_red;
    wire  [1:0] b_o_req, b_i_ack, b_o_err;
    wire  [3:0] b_leds, b_disp0, b_disp1;

    pakout_chk #(
        .NCH(2), .MIN_ADDR(1), .MAX_ADDR(3), .SRC_ADDR(3), .ASZ(4), .DSZ(4), .RSZ(4),
        .RED_MODE(0), .INIT_RED(15), .CW(16)
    ) dut0 (
        .i_clk(clk), .i_rst(rst), .i_en(b_en),
        .o_src(b_o_src), .o_dst(b_o_dst), .o_dat(b_o_dat), .o_red(b_o_red), .o_req(b_o_req), .o_ack(b_o_ack),
        .i_src(b_i_src), .i_dst(b_i_dst), .i_dat(b_i_dat), .i_red(b_i_red), .i_req(b_i_req), .i_ack(b_i_ack),
        .dbg_case(b_dbg_case), .dbg_leds(b_leds), .dbg_disp0(b_disp0), .dbg_disp1(b_disp1),
        .o_err(b_o_err)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] q0 [$];
    logic [15:0] q1 [$];

    // Independent redundancy model: with 4-bit fields the fold is a plain XOR of the three fields
    function automatic logic [3:0] red_of(input logic [3:0] s, input logic [3:0] d, input logic [3:0] t);
        return s ^ d ^ t;
    endfunction

    // Hold both DUTs in reset with every bench-driven input idle
    task automatic apply_reset;
        rst = 1'b1; en = 2'b00; loop = 1'b0; tb_o_ack = 2'b00; tb_i_req = 2'b00;
        b_i_req = 2'b00; dbg_case = 4'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Select a debug view and wait for its registered result
    task automatic view(input int ch, input bit sink);
        dbg_case = {3'(ch), sink};
        @(negedge clk);
    endtask

    // Act as the sender into a checker; returns two cycles after the capture edge
    task automatic send_pkt(input bit alt, input int ch, input logic [3:0] s, input logic [3:0] d,
                            input logic [3:0] t, input logic [3:0] r);
        int n;
        if (!alt) begin
            tb_i_src[ch*4 +: 4] = s; tb_i_dst[ch*4 +: 4] = d;
            tb_i_dat[ch*4 +: 4] = t; tb_i_red[ch*4 +: 4] = r; tb_i_req[ch] = 1'b1;
        end else begin
            b_i_src[ch*4 +: 4] = s; b_i_dst[ch*4 +: 4] = d;
            b_i_dat[ch*4 +: 4] = t; b_i_red[ch*4 +: 4] = r; b_i_req[ch] = 1'b1;
        end
        n = 0;
        while (!(alt ? b_i_ack[ch] : i_ack[ch]) && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (n >= 20) begin errors++; $display("[TB] FAIL ack_rise ch%0d: i_ack got 0 required 1", ch); end
        if (!alt) tb_i_req[ch] = 1'b0; else b_i_req[ch] = 1'b0;
        n = 0;
        while ((alt ? b_i_ack[ch] : i_ack[ch]) && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (n >= 20) begin errors++; $display("[TB] FAIL ack_fall ch%0d: i_ack got 1 required 0", ch); end
        @(negedge clk);
    endtask

    // Reset values on all outputs, then the first registered debug view
    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (o_req !== 2'b00) begin errors++; $display("[TB] FAIL rst_req: got %b required 00", o_req); end
        checks++; if (i_ack !== 2'b00) begin errors++; $display("[TB] FAIL rst_ack: got %b required 00", i_ack); end
        checks++; if (o_err !== 2'b00) begin errors++; $display("[TB] FAIL rst_err: got %b required 00", o_err); end
        checks++; if ({dbg_leds, dbg_disp0, dbg_disp1} !== 12'h000) begin errors++; $display("[TB] FAIL rst_dbg: got %h required 000", {dbg_leds, dbg_disp0, dbg_disp1}); end
        checks++; if (o_src !== 8'h33) begin errors++; $display("[TB] FAIL rst_src: got %h required 33", o_src); end
        checks++; if (o_dst !== 8'h33) begin errors++; $display("[TB] FAIL rst_dst: got %h required 33", o_dst); end
        checks++; if (o_dat !== 8'h00) begin errors++; $display("[TB] FAIL rst_dat: got %h required 00", o_dat); end
        checks++; if (o_red !== 8'hFF) begin errors++; $display("[TB] FAIL rst_red: got %h required ff", o_red); end
        rst = 1'b0;
        view(0, 1'b0);
        checks++; if ({dbg_leds, dbg_disp0, dbg_disp1} !== 12'h003) begin errors++; $display("[TB] FAIL rst_view: got %h required 003", {dbg_leds, dbg_disp0, dbg_disp1}); end
    endtask

    // Both channels looped back for 40 packets; generated fields are scoreboarded at each request
    task automatic test_loopback;
        logic [1:0]  prev;
        logic [15:0] exp_v, act;
        int cnt [2];
        int cyc;
        logic [3:0] d;
        apply_reset;
        for (int i = 0; i < 40; i++) begin
            d = 4'((i % 3) + 1);
            q0.push_back({4'h3, d, 4'(i % 16), red_of(4'h3, d, 4'(i % 16))});
            q1.push_back({4'h3, d, 4'(i % 16), red_of(4'h3, d, 4'(i % 16))});
        end
        cnt[0] = 0; cnt[1] = 0; prev = 2'b00; cyc = 0;
        loop = 1'b1;
        en = 2'b11;
        while ((cnt[0] < 40 || cnt[1] < 40) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            for (int ch = 0; ch < 2; ch++) begin
                if (o_req[ch] && !prev[ch]) begin
                    act = {o_src[ch*4 +: 4], o_dst[ch*4 +: 4], o_dat[ch*4 +: 4], o_red[ch*4 +: 4]};
                    exp_v = 16'hxxxx;
                    if (ch == 0 && q0.size() > 0) exp_v = q0.pop_front();
                    if (ch == 1 && q1.size() > 0) exp_v = q1.pop_front();
                    checks++;
                    if (act !== exp_v) begin errors++; $display("[TB] FAIL loop_pkt ch%0d #%0d: got %h required %h", ch, cnt[ch], act, exp_v); end
                    cnt[ch]++;
                    if (cnt[ch] == 40) en[ch] = 1'b0;
                end
            end
            prev = o_req;
        end
        checks++;
        if (cyc >= 3000) begin errors++; $display("[TB] FAIL loop_timeout: got %0d/%0d packets required 40", cnt[0], cnt[1]); end
        repeat (16) @(negedge clk);
        checks++; if (o_err !== 2'b00) begin errors++; $display("[TB] FAIL loop_err: got %b required 00", o_err); end
        checks++; if (o_req !== 2'b00) begin errors++; $display("[TB] FAIL loop_idle: got %b required 00", o_req); end
        checks++; if (q0.size() + q1.size() != 0) begin errors++; $display("[TB] FAIL loop_queue: got %0d left required 0", q0.size() + q1.size()); end
        for (int ch = 0; ch < 2; ch++) begin
            view(ch, 1'b1);
            checks++; if ({dbg_leds, dbg_disp0, dbg_disp1} !== 12'h008) begin errors++; $display("[TB] FAIL loop_sink ch%0d: got %h required 008", ch, {dbg_leds, dbg_disp0, dbg_disp1}); end
            view(ch, 1'b0);
            checks++; if ({dbg_leds, dbg_disp0, dbg_disp1} !== 12'h081) begin errors++; $display("[TB] FAIL loop_src ch%0d: got %h required 081", ch, {dbg_leds, dbg_disp0, dbg_disp1}); end
        end
        loop = 1'b0;
    endtask

    // Wrong source address on channel 1, third packet
    task automatic test_src_inject;
        logic [3:0] s;
        apply_reset;
        for (int p = 0; p < 4; p++) begin
            s = (p == 2) ? 4'h5 : 4'h3;
            send_pkt(1'b0, 1, s, 4'h1, 4'(p), red_of(s, 4'h1, 4'(p)));
            if (p == 1) begin
                checks++; if (o_err !== 2'b00) begin errors++; $display("[TB] FAIL src_before: got %b required 00", o_err); end
            end
            if (p >= 2) begin
                checks++; if (o_err !== 2'b10) begin errors++; $display("[TB] FAIL src_oerr p%0d: got %b required 10", p, o_err); end
                view(1, 1'b1);
                checks++; if ({dbg_leds, dbg_disp0, dbg_disp1} !== {4'b0001, 4'h5, 4'(p + 1)}) begin errors++; $display("[TB] FAIL src_view p%0d: got %h required %h", p, {dbg_leds, dbg_disp0, dbg_disp1}, {4'b0001, 4'h5, 4'(p + 1)}); end
            end
        end
    endtask

    // Data sequence skip 7 -> 9 on channel 0 with a non-zero first value
    task automatic test_seq_skip;
        logic [3:0] dats [5];
        dats = '{4'd5, 4'd6, 4'd7, 4'd9, 4'd10};
        apply_reset;
        for (int p = 0; p < 5; p++) begin
            send_pkt(1'b0, 0, 4'h3, 4'h2, dats[p], red_of(4'h3, 4'h2, dats[p]));
            if (p < 3) begin
                checks++; if (o_err !== 2'b00) begin errors++; $display("[TB] FAIL seq_clean p%0d: got %b required 00", p, o_err); end
            end else begin
                view(0, 1'b1);
                checks++; if ({dbg_leds, dbg_disp0, dbg_disp1} !== {4'b0010, 4'h9, 4'(p + 1)}) begin errors++; $display("[TB] FAIL seq_view p%0d: got %h required %h", p, {dbg_leds, dbg_disp0, dbg_disp1}, {4'b0010, 4'h9, 4'(p + 1)}); end
            end
        end
    endtask

    // Corrupted redundancy with computed mode, then constant mode on the second instance
    task automatic test_red;
        apply_reset;
        send_pkt(1'b0, 0, 4'h3, 4'h1, 4'h0, red_of(4'h3, 4'h1, 4'h0));
        checks++; if (o_err !== 2'b00) begin errors++; $display("[TB] FAIL red_good: got %b required 00", o_err); end
        send_pkt(1'b0, 0, 4'h3, 4'h1, 4'h1, red_of(4'h3, 4'h1, 4'h1) ^ 4'b0100);
        view(0, 1'b1);
        checks++; if ({dbg_leds, dbg_disp0, dbg_disp1} !== {4'b0100, 4'h7, 4'h2}) begin errors++; $display("[TB] FAIL red_view: got %h required 472", {dbg_leds, dbg_disp0, dbg_disp1}); end
        send_pkt(1'b1, 0, 4'h3, 4'h1, 4'h0, 4'hF);
        send_pkt(1'b1, 0, 4'h3, 4'h2, 4'h1, 4'hF);
        checks++; if (b_o_err !== 2'b00) begin errors++; $display("[TB] FAIL red_const_good: got %b required 00", b_o_err); end
        send_pkt(1'b1, 0, 4'h3, 4'h3, 4'h2, 4'hE);
        checks++; if (b_o_err !== 2'b01) begin errors++; $display("[TB] FAIL red_const_bad: got %b required 01", b_o_err); end
    endtask

    // Destination range edges: both bounds accepted, one past either bound flagged
    task automatic test_dst;
        apply_reset;
        send_pkt(1'b0, 1, 4'h3, 4'h1, 4'h0, red_of(4'h3, 4'h1, 4'h0));
        send_pkt(1'b0, 1, 4'h3, 4'h3, 4'h1, red_of(4'h3, 4'h3, 4'h1));
        checks++; if (o_err !== 2'b00) begin errors++; $display("[TB] FAIL dst_edges: got %b required 00", o_err); end
        send_pkt(1'b0, 1, 4'h3, 4'h4, 4'h2, red_of(4'h3, 4'h4, 4'h2));
        view(1, 1'b1);
        checks++; if ({dbg_leds, dbg_disp0, dbg_disp1} !== {4'b1000, 4'h4, 4'h3}) begin errors++; $display("[TB] FAIL dst_high: got %h required 843", {dbg_leds, dbg_disp0, dbg_disp1}); end
        apply_reset;
        send_pkt(1'b0, 1, 4'h3, 4'h0, 4'h0, red_of(4'h3, 4'h0, 4'h0));
        checks++; if (o_err !== 2'b10) begin errors++; $display("[TB] FAIL dst_low: got %b required 10", o_err); end
    endtask

    // Bench as a slow receiver on channel 0, then reset while a request is pending
    task automatic test_slow_peer;
        logic [15:0] exp_v, act;
        int n;
        apply_reset;
        q0.push_back({4'h3, 4'h1, 4'h0, red_of(4'h3, 4'h1, 4'h0)});
        q0.push_back({4'h3, 4'h2, 4'h1, red_of(4'h3, 4'h2, 4'h1)});
        en[0] = 1'b1;
        n = 0;
        while (!o_req[0] && n < 20) begin @(negedge clk); n++; end
        checks++; if (n >= 20) begin errors++; $display("[TB] FAIL slow_req1: o_req got 0 required 1"); end
        exp_v = q0.pop_front();
        for (int c = 0; c < 5; c++) begin
            act = {o_src[3:0], o_dst[3:0], o_dat[3:0], o_red[3:0]};
            checks++; if ({o_req[0], act} !== {1'b1, exp_v}) begin errors++; $display("[TB] FAIL slow_hold c%0d: got %b/%h required 1/%h", c, o_req[0], act, exp_v); end
            @(negedge clk);
        end
        tb_o_ack[0] = 1'b1;
        n = 0;
        while (o_req[0] && n < 20) begin @(negedge clk); n++; end
        checks++; if (n >= 20) begin errors++; $display("[TB] FAIL slow_release: o_req got 1 required 0"); end
        tb_o_ack[0] = 1'b0;
        view(0, 1'b0);
        checks++; if (dbg_disp0 !== 4'h1) begin errors++; $display("[TB] FAIL slow_sent: got %h required 1", dbg_disp0); end
        n = 0;
        while (!o_req[0] && n < 20) begin @(negedge clk); n++; end
        exp_v = q0.pop_front();
        act = {o_src[3:0], o_dst[3:0], o_dat[3:0], o_red[3:0]};
        checks++; if ({o_req[0], act} !== {1'b1, exp_v}) begin errors++; $display("[TB] FAIL slow_pkt2: got %b/%h required 1/%h", o_req[0], act, exp_v); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({o_req, i_ack} !== 4'b0000) begin errors++; $display("[TB] FAIL slow_rst_req: got %b required 0000", {o_req, i_ack}); end
        en = 2'b00;
        rst = 1'b0;
        view(0, 1'b0);
        checks++; if ({dbg_leds, dbg_disp0, dbg_disp1} !== 12'h003) begin errors++; $display("[TB] FAIL slow_rst_view: got %h required 003", {dbg_leds, dbg_disp0, dbg_disp1}); end
    endtask

    // Selector pointing past the last channel shows nothing
    task automatic test_dbg_oob;
        dbg_case = 4'hF;
        @(negedge clk);
        checks++; if ({dbg_leds, dbg_disp0, dbg_disp1} !== 12'h000) begin errors++; $display("[TB] FAIL dbg_oob15: got %h required 000", {dbg_leds, dbg_disp0, dbg_disp1}); end
        view(0, 1'b0);
        dbg_case = 4'h4;
        @(negedge clk);
        checks++; if ({dbg_leds, dbg_disp0, dbg_disp1} !== 12'h000) begin errors++; $display("[TB] FAIL dbg_oob4: got %h required 000", {dbg_leds, dbg_disp0, dbg_disp1}); end
    endtask

    // Scenario sequence and summary
    initial begin
        test_reset;
        test_loopback;
        test_src_inject;
        test_seq_skip;
        test_red;
        test_dst;
        test_slow_peer;
        test_dbg_oob;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Runaway guard
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, required finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
